// File: rtl/perf_sampler_if.sv
// Port bundle for perf_sampler: CSR access, counter-block SRAM port, sample stream and status.
// slave is the sampler side of the bundle; master is the surrounding CSR file, counter block and trace sink.
interface perf_sampler_if #(
   parameter int unsigned SEQ_W = 16
);
   logic              enable_i;
   logic [31:0]       period_i;
   logic              clear_on_read_i;
   logic              csr_req_i;
   logic [4:0]        csr_addr_i;
   logic              csr_we_i;
   logic [63:0]       csr_wdata_i;
   logic [63:0]       csr_rdata_o;
   logic [4:0]        perf_addr_o;
   logic              perf_we_o;
   logic [63:0]       perf_wdata_o;
   logic [63:0]       perf_rdata_i;
   logic              smp_valid_o;
   logic              smp_ready_i;
   logic [4:0]        smp_addr_o;
   logic [63:0]       smp_data_o;
   logic [SEQ_W-1:0]  smp_seq_o;
   logic              busy_o;
   logic              overrun_o;

   modport slave (
      input  enable_i, period_i, clear_on_read_i,
      input  csr_req_i, csr_addr_i, csr_we_i, csr_wdata_i,
      input  perf_rdata_i, smp_ready_i,
      output csr_rdata_o, perf_addr_o, perf_we_o, perf_wdata_o,
      output smp_valid_o, smp_addr_o, smp_data_o, smp_seq_o, busy_o, overrun_o
   );

   modport master (
      output enable_i, period_i, clear_on_read_i,
      output csr_req_i, csr_addr_i, csr_we_i, csr_wdata_i,
      output perf_rdata_i, smp_ready_i,
      input  csr_rdata_o, perf_addr_o, perf_we_o, perf_wdata_o,
      input  smp_valid_o, smp_addr_o, smp_data_o, smp_seq_o, busy_o, overrun_o
   );
endinterface

// File: rtl/perf_sampler.sv
// Periodic counter scanner sharing the counter port with CSR (CSR wins); first record T+1 after trigger.
// Backpressure: a full sample FIFO or a CSR access stalls the scan one slot at a time, nothing is dropped.
module perf_sampler #(
   parameter int unsigned NR_COUNTERS = 14,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned SEQ_W       = 16
) (
   input logic           clk_i,
   input logic           rst_ni,
   perf_sampler_if.slave bus
);
   localparam int unsigned AW       = $clog2(FIFO_DEPTH);
   localparam logic [4:0]  LAST_IDX = 5'(NR_COUNTERS - 1);

   typedef struct packed {
      logic [4:0]       addr;
      logic [63:0]      data;
      logic [SEQ_W-1:0] seq;
   } smp_t;

   typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [4:0]       idx_q, idx_d;
   logic [SEQ_W-1:0] epoch_q, epoch_d;
   logic             ovr_q, ovr_d;

   logic [31:0]      tmr_q, per_q, eff_period;
   logic             run, trig;

   logic [AW:0]      wr_q, rd_q;
   smp_t             mem_q [FIFO_DEPTH];
   smp_t             head;
   logic             full, empty, push, pop;
   logic             scanning, grant;

   // The period is only re-read at count 0, so a change lands at the next wrap.
   always_comb begin
      eff_period = (tmr_q == 32'd0) ? bus.period_i : per_q;
      run        = bus.enable_i && (eff_period != 32'd0);
      trig       = run && (tmr_q == eff_period - 32'd1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tmr_q <= '0;
         per_q <= '0;
      end else if (!run) begin
         tmr_q <= '0;
         per_q <= '0;
      end else begin
         tmr_q <= trig ? 32'd0 : tmr_q + 32'd1;
         per_q <= eff_period;
      end
   end

   // Slot 0 is taken in the trigger cycle itself to give T+1 latency.
   always_comb begin
      full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      empty    = (wr_q == rd_q);
      scanning = (state_q == SCAN) || trig;
      grant    = bus.enable_i && scanning && !bus.csr_req_i && !full;
      push     = grant;
      pop      = !empty && bus.smp_ready_i;
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      epoch_d = epoch_q;
      ovr_d   = ovr_q || ((state_q == SCAN) && trig);
      if ((state_q == IDLE) && trig) begin
         state_d = SCAN;
      end
      if (grant) begin
         if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            epoch_d = epoch_q + SEQ_W'(1);
            state_d = IDLE;
         end else begin
            idx_d = idx_q + 5'd1;
         end
      end
      if (!bus.enable_i) begin
         state_d = IDLE;
         idx_d   = '0;
         ovr_d   = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         idx_q   <= '0;
         epoch_q <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         epoch_q <= epoch_d;
         ovr_q   <= ovr_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q <= '0;
         rd_q <= '0;
      end else if (!bus.enable_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + 1'b1;
         if (pop)  rd_q <= rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_q[AW-1:0]] <= '{addr: idx_q, data: bus.perf_rdata_i, seq: epoch_q};
   end

   // Stale storage is masked so the record fields read 0 whenever nothing is valid.
   always_comb begin
      head            = mem_q[rd_q[AW-1:0]];
      bus.smp_valid_o = !empty;
      bus.smp_addr_o  = empty ? 5'd0 : head.addr;
      bus.smp_data_o  = empty ? 64'd0 : head.data;
      bus.smp_seq_o   = empty ? '0 : head.seq;
      bus.busy_o      = (state_q == SCAN);
      bus.overrun_o   = ovr_q;
      bus.csr_rdata_o = bus.perf_rdata_i;
   end

   always_comb begin
      bus.perf_addr_o  = '0;
      bus.perf_we_o    = 1'b0;
      bus.perf_wdata_o = '0;
      if (bus.csr_req_i) begin
         bus.perf_addr_o  = bus.csr_addr_i;
         bus.perf_we_o    = bus.csr_we_i;
         bus.perf_wdata_o = bus.csr_wdata_i;
      end else if (grant) begin
         bus.perf_addr_o = idx_q;
         bus.perf_we_o   = bus.clear_on_read_i;
      end
   end
endmodule

// File: tb/tb_perf_sampler.sv
// Bench for perf_sampler: behavioural counter block plus a scoreboard of expected sample records.
module tb_perf_sampler;
   localparam int NC = 14;

   typedef struct {
      logic [4:0]  addr;
      logic [63:0] data;
      logic [15:0] seq;
      int          cyc;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          cyc = 0;
   int          n_chk = 0;
   int          n_pass = 0;
   rec_t        exp_q [$];
   logic [63:0] exp_cnt [NC];
   logic [63:0] cnt_mem [NC];
   logic        seed_req = 1'b0;
   logic [63:0] seed_base = '0;
   int          c0;
   int          r0;

   perf_sampler_if #(.SEQ_W(16)) smp_if ();

   perf_sampler #(.NR_COUNTERS(NC), .FIFO_DEPTH(4), .SEQ_W(16)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (smp_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Counter block: combinational read, write on the clock edge, no events counted.
   assign smp_if.perf_rdata_i = (smp_if.perf_addr_o < 5'(NC)) ? cnt_mem[smp_if.perf_addr_o] : 64'd0;

   always @(posedge clk) begin
      if (seed_req) begin
         for (int i = 0; i < NC; i++) cnt_mem[i] <= seed_base + 64'(i) * 64'h0000_0101_0000_0011;
      end else if (smp_if.perf_we_o && (smp_if.perf_addr_o < 5'(NC))) begin
         cnt_mem[smp_if.perf_addr_o] <= smp_if.perf_wdata_o;
      end
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) tick();
   endtask

   task automatic seed(input logic [63:0] base);
      seed_base = base;
      seed_req  = 1'b1;
      for (int i = 0; i < NC; i++) exp_cnt[i] = base + 64'(i) * 64'h0000_0101_0000_0011;
      tick();
      seed_req = 1'b0;
   endtask

   task automatic push_scan(input int seq, input int first_cyc, input int gap_at, input int gap);
      rec_t r;
      for (int i = 0; i < NC; i++) begin
         r.addr = 5'(i);
         r.data = exp_cnt[i];
         r.seq  = 16'(seq);
         r.cyc  = (first_cyc < 0) ? -1 : first_cyc + i + ((i >= gap_at) ? gap : 0);
         exp_q.push_back(r);
      end
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      chk(tag, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic csr_access(input logic we, input logic [4:0] addr, input logic [63:0] wdata);
      smp_if.csr_req_i   = 1'b1;
      smp_if.csr_we_i    = we;
      smp_if.csr_addr_i  = addr;
      smp_if.csr_wdata_i = wdata;
   endtask

   // Monitor: every accepted record must be the next one the scoreboard expects.
   always @(negedge clk) begin
      if (rst_n && smp_if.smp_valid_o && smp_if.smp_ready_i) begin
         chk("rec_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            rec_t e;
            e = exp_q.pop_front();
            chk("rec_addr", 64'(smp_if.smp_addr_o), 64'(e.addr));
            chk("rec_data", smp_if.smp_data_o, e.data);
            chk("rec_seq", 64'(smp_if.smp_seq_o), 64'(e.seq));
            if (e.cyc >= 0) chk("rec_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      smp_if.enable_i        = 1'b0;
      smp_if.period_i        = '0;
      smp_if.clear_on_read_i = 1'b0;
      smp_if.csr_req_i       = 1'b0;
      smp_if.csr_addr_i      = '0;
      smp_if.csr_we_i        = 1'b0;
      smp_if.csr_wdata_i     = '0;
      smp_if.smp_ready_i     = 1'b1;
      repeat (3) tick();
      chk("rst_valid", 64'(smp_if.smp_valid_o), 64'd0);
      chk("rst_busy", 64'(smp_if.busy_o), 64'd0);
      chk("rst_overrun", 64'(smp_if.overrun_o), 64'd0);
      chk("rst_perf_we", 64'(smp_if.perf_we_o), 64'd0);
      chk("rst_smp_data", smp_if.smp_data_o, 64'd0);
      rst_n = 1'b1;
      seed(64'hA5A5_0000_0000_1000);
      tick();

      // 1: uncontended scans on a 100-cycle period, exact record timing
      smp_if.period_i = 32'd100;
      smp_if.enable_i = 1'b1;
      c0 = cyc;
      push_scan(0, c0 + 100, 99, 0);
      push_scan(1, c0 + 200, 99, 0);
      wait_cyc(c0 + 105);
      chk("t1_busy_mid", 64'(smp_if.busy_o), 64'd1);
      wait_drain("t1_drain", 400);
      chk("t1_busy_end", 64'(smp_if.busy_o), 64'd0);
      chk("t1_overrun", 64'(smp_if.overrun_o), 64'd0);
      smp_if.enable_i = 1'b0;
      tick();

      // 2: three CSR read cycles at idx 5 stall the scan by exactly three slots
      smp_if.enable_i = 1'b1;
      c0 = cyc;
      push_scan(2, c0 + 100, 5, 3);
      wait_cyc(c0 + 104);
      csr_access(1'b0, 5'd2, 64'd0);
      @(negedge clk);
      chk("t2_csr_rdata", smp_if.csr_rdata_o, exp_cnt[2]);
      chk("t2_csr_addr", 64'(smp_if.perf_addr_o), 64'd2);
      chk("t2_busy", 64'(smp_if.busy_o), 64'd1);
      wait_cyc(c0 + 107);
      smp_if.csr_req_i = 1'b0;
      wait_drain("t2_drain", 200);
      smp_if.enable_i = 1'b0;
      tick();

      // 3: consumer stalls, four records held, scan parked on idx 4
      smp_if.smp_ready_i = 1'b0;
      smp_if.enable_i    = 1'b1;
      c0 = cyc;
      push_scan(3, -1, 99, 0);
      wait_cyc(c0 + 110);
      chk("t3_valid", 64'(smp_if.smp_valid_o), 64'd1);
      chk("t3_busy", 64'(smp_if.busy_o), 64'd1);
      chk("t3_head_addr", 64'(smp_if.smp_addr_o), 64'd0);
      chk("t3_port_idle", 64'(smp_if.perf_addr_o), 64'd0);
      chk("t3_none_popped", 64'(exp_q.size()), 64'(NC));
      smp_if.smp_ready_i = 1'b1;
      wait_drain("t3_drain", 100);
      smp_if.enable_i = 1'b0;
      tick();

      // 4: CSR write then clear-on-read scan returns the pre-clear value
      csr_access(1'b1, 5'd5, 64'h1234);
      #1;
      chk("t4_wr_we", 64'(smp_if.perf_we_o), 64'd1);
      chk("t4_wr_data", smp_if.perf_wdata_o, 64'h1234);
      tick();
      smp_if.csr_req_i = 1'b0;
      smp_if.csr_we_i  = 1'b0;
      exp_cnt[5] = 64'h1234;
      smp_if.clear_on_read_i = 1'b1;
      smp_if.enable_i        = 1'b1;
      push_scan(4, -1, 99, 0);
      for (int i = 0; i < NC; i++) exp_cnt[i] = 64'd0;
      wait_drain("t4_drain", 300);
      smp_if.enable_i        = 1'b0;
      smp_if.clear_on_read_i = 1'b0;
      tick();
      csr_access(1'b0, 5'd5, 64'd0);
      #1;
      chk("t4_cleared_5", smp_if.csr_rdata_o, exp_cnt[5]);
      smp_if.csr_addr_i = 5'd13;
      #1;
      chk("t4_cleared_13", smp_if.csr_rdata_o, exp_cnt[13]);
      tick();
      smp_if.csr_req_i = 1'b0;

      // 5: period 10 with a stalled consumer raises overrun; disable flushes
      seed(64'h0F0F_2222_0000_0000);
      smp_if.smp_ready_i = 1'b0;
      smp_if.period_i    = 32'd10;
      smp_if.enable_i    = 1'b1;
      c0 = cyc;
      wait_cyc(c0 + 19);
      chk("t5_overrun_before", 64'(smp_if.overrun_o), 64'd0);
      wait_cyc(c0 + 20);
      chk("t5_overrun_set", 64'(smp_if.overrun_o), 64'd1);
      chk("t5_busy", 64'(smp_if.busy_o), 64'd1);
      chk("t5_valid", 64'(smp_if.smp_valid_o), 64'd1);
      smp_if.enable_i = 1'b0;
      tick();
      chk("t5_flush_valid", 64'(smp_if.smp_valid_o), 64'd0);
      chk("t5_flush_overrun", 64'(smp_if.overrun_o), 64'd0);
      chk("t5_flush_busy", 64'(smp_if.busy_o), 64'd0);
      smp_if.smp_ready_i = 1'b1;
      tick();

      // 6: epoch survives disable; async reset mid-scan restarts epoch at 0
      smp_if.enable_i = 1'b1;
      c0 = cyc;
      push_scan(5, c0 + 10, 99, 0);
      wait_cyc(c0 + 14);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 64'(smp_if.smp_valid_o), 64'd0);
      chk("t6_rst_busy", 64'(smp_if.busy_o), 64'd0);
      chk("t6_rst_seq", 64'(smp_if.smp_seq_o), 64'd0);
      chk("t6_rst_perf_addr", 64'(smp_if.perf_addr_o), 64'd0);
      exp_q.delete();
      smp_if.period_i = 32'd20;
      tick();
      tick();
      rst_n = 1'b1;
      r0 = cyc;
      push_scan(0, r0 + 20, 99, 0);
      wait_drain("t6_drain", 100);
      chk("t6_overrun", 64'(smp_if.overrun_o), 64'd0);
      smp_if.enable_i = 1'b0;
      tick();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/perf_sampler.md
Name: perf_sampler

Overview:
- Periodic sampling controller for the machine performance-counter block.
- Owns that block's single SRAM-like port (addr/we/wdata/rdata).
- Arbitrates the port between CSR-file accesses (always priority) and an internal scan engine. Every period_i cycles the engine walks all counters and streams {index, value, epoch} records over a valid/ready interface to trace/debug logic.
- Optionally clears each counter as it is read.

Parameters:
- NR_COUNTERS, 14: counters scanned, port indices 0..NR_COUNTERS-1.
- FIFO_DEPTH, 4: sample FIFO entries (power of two, ≥2).
- SEQ_W, 16: width of scan epoch tag.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- enable_i  in  1  sampling enable; low aborts scan, flushes FIFO, clears timer and overrun.
- period_i  in  32  trigger interval in cycles; 0 = never trigger.
- clear_on_read_i  in  1  zero each counter when sampled.
- csr_req_i  in  1  CSR access request this cycle.
- csr_addr_i  in  5  CSR counter index.
- csr_we_i  in  1  CSR write enable (qualified by csr_req_i).
- csr_wdata_i  in  64  CSR write data.
- csr_rdata_o  out  64  read data to CSR file.
- perf_addr_o  out  5  counter port address.
- perf_we_o  out  1  counter port write enable.
- perf_wdata_o  out  64  counter port write data.
- perf_rdata_i  in  64  counter port read data (combinational, same cycle as address).
- smp_valid_o  out  1  sample record available.
- smp_ready_i  in  1  consumer accepts record.
- smp_addr_o  out  5  counter index of record.
- smp_data_o  out  64  counter value of record.
- smp_seq_o  out  SEQ_W  epoch of record.
- busy_o  out  1  scan in progress.
- overrun_o  out  1  sticky: trigger arrived while scanning.

Interface rules:
- Reset rst_ni: asynchronous, active-low. Clock clk_i.
- Outputs are 0 during/after reset.

Behaviour:
- Port mux (combinational):
  - csr_req_i=1: perf_addr_o=csr_addr_i, perf_we_o=csr_we_i, perf_wdata_o=csr_wdata_i.
  - Else if SCAN and slot granted: perf_addr_o=idx, perf_we_o=clear_on_read_i, perf_wdata_o=0.
  - Else addr/we/wdata = 0.
  - csr_rdata_o = perf_rdata_i always.
- Timer:
  - Runs only when enable_i=1 and period_i≠0.
  - Counts 0..period_i-1. At period_i-1 it raises trigger for one cycle and wraps to 0.
  - Keeps running during SCAN.
  - period_i changes take effect at the next wrap.
- FSM, IDLE:
  - busy_o=0.
  - Trigger → SCAN with idx=0.
- FSM, SCAN:
  - busy_o=1.
  - Slot granted = !csr_req_i && FIFO not full. Full stalls even if a pop occurs the same cycle.
  - On grant: push {idx, perf_rdata_i, epoch}. The pushed value is pre-clear because the counter block does write-after-read.
  - On grant with idx<NR_COUNTERS-1: idx+1.
  - On grant with idx=NR_COUNTERS-1: epoch+1 (wraps mod 2^SEQ_W), → IDLE.
  - Trigger during SCAN: dropped, overrun_o←1.
- Clear-on-read: an increment in the same cycle as the clear is lost. This is accepted by design.
- enable_i falling:
  - Next cycle: FSM=IDLE, idx=0, timer=0, FIFO empty, overrun_o=0.
  - epoch is kept.
  - CSR path is unaffected.
- FIFO: first-word-fall-through.
  - smp_valid_o = !empty.
  - Pop on valid&&ready.
  - Order preserved; no duplication or loss of scan indices.
- Latency: trigger cycle T → first record valid at T+1 when uncontended. A full scan takes NR_COUNTERS cycles uncontended.
- Reset mid-scan: immediate return to IDLE. FIFO, epoch, timer, overrun all 0.

Test Plan:
1. enable=1, period=100, ready=1, no CSR → records addr 0..13, seq=0, on cycles 100..113 after enable; second scan seq=1 starting cycle 200.
2. csr_req_i high 3 cycles mid-scan at idx 5 (read addr 2) → scan stalls exactly 3 cycles; csr_rdata_o = counter 2; records stay contiguous 0..13.
3. smp_ready_i=0 → 4 records (idx 0..3) held, busy_o=1, stall at idx 4; raise ready → remaining 10 records in order, no gaps.
4. CSR write 0x1234 to counter 5, clear_on_read=1, scan → record addr 5 data 0x1234; later CSR read of counter 5 returns 0 (absent events).
5. period=10, ready=0 → overrun_o=1 after cycle 20; drop enable_i → next cycle smp_valid_o=0, overrun_o=0, busy_o=0.
6. Assert rst_ni mid-scan → all outputs 0 asynchronously; after release, first scan seq=0.
